// File: rtl/xor_fold_pkg.sv
// Shared widths, S1 beat layout and error-counter limit for the XOR fold/unfold link.
package xor_fold_pkg;

    localparam int HALF_W = 16;
    localparam int FULL_W = 2 * HALF_W;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    typedef struct packed {
        logic [HALF_W-1:0] aa;
        logic [HALF_W-1:0] bb;
        logic [HALF_W-1:0] ahi;
        logic [HALF_W-1:0] bhi;
        logic [1:0]        par;
    } s1_beat_t;

endpackage

// File: rtl/xor_unfold_stage.sv
// One valid/ready register stage; payload loads only when the stage advances with a valid beat.
module xor_unfold_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/xor_unfold_32bit.sv
// Receive-side XOR unfold: two-stage pipeline recovering {hi, fold ^ hi} with word/error counters.
// Parity checking and err_cnt exist only when XOR_UNFOLD_PARITY_EN is defined.
module xor_unfold_32bit #(
    parameter int HALF_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [HALF_W-1:0]   in_aa,
    input  logic [HALF_W-1:0]   in_bb,
    input  logic [HALF_W-1:0]   in_ahi,
    input  logic [HALF_W-1:0]   in_bhi,
    input  logic [1:0]          in_par,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*HALF_W-1:0] out_a,
    output logic [2*HALF_W-1:0] out_b,
    output logic                out_err,
    output logic [7:0]          err_cnt,
    output logic [CNT_W-1:0]    word_cnt
);

    import xor_fold_pkg::ERR_CNT_MAX;

    typedef struct packed {
        logic [HALF_W-1:0] aa;
        logic [HALF_W-1:0] bb;
        logic [HALF_W-1:0] ahi;
        logic [HALF_W-1:0] bhi;
`ifdef XOR_UNFOLD_PARITY_EN
        logic [1:0]        par;
`endif
    } s1_t;

    typedef struct packed {
`ifdef XOR_UNFOLD_PARITY_EN
        logic              err;
`endif
        logic [2*HALF_W-1:0] b;
        logic [2*HALF_W-1:0] a;
    } s2_t;

    s1_t  s1_d, s1_q;
    s2_t  s2_d, s2_q;
    logic s1_valid;
    logic s2_adv;
    logic fire;

    always_comb begin
        s1_d     = '0;
        s1_d.aa  = in_aa;
        s1_d.bb  = in_bb;
        s1_d.ahi = in_ahi;
        s1_d.bhi = in_bhi;
`ifdef XOR_UNFOLD_PARITY_EN
        s1_d.par = in_par;
`endif
    end

    xor_unfold_stage #(.W($bits(s1_t))) u_s1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_d),
        .out_valid (s1_valid),
        .out_ready (s2_adv),
        .out_data  (s1_q)
    );

    always_comb begin
        s2_d   = '0;
        s2_d.a = {s1_q.ahi, s1_q.aa ^ s1_q.ahi};
        s2_d.b = {s1_q.bhi, s1_q.bb ^ s1_q.bhi};
`ifdef XOR_UNFOLD_PARITY_EN
        s2_d.err = ((^s1_q.aa) != s1_q.par[0]) || ((^s1_q.bb) != s1_q.par[1]);
`endif
    end

    xor_unfold_stage #(.W($bits(s2_t))) u_s2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_ready  (s2_adv),
        .in_data   (s2_d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_a = s2_q.a;
    assign out_b = s2_q.b;
    assign fire  = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (fire) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

`ifdef XOR_UNFOLD_PARITY_EN
    assign out_err = s2_q.err;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (fire && out_err && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    // Parity input is accepted but has no function in this build.
    logic unused_par;
    assign unused_par = ^in_par;
    assign out_err    = 1'b0;
    assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_xor_unfold_32bit.sv
// Bench for xor_unfold_32bit: sends folded random words and checks recovery of the original words.
module tb_xor_unfold_32bit;

`ifdef XOR_UNFOLD_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_aa, in_bb, in_ahi, in_bhi;
    logic [1:0]  in_par;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a, out_b;
    logic        out_err;
    logic [7:0]  err_cnt;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    xor_unfold_32bit #(.HALF_W(16), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_aa     (in_aa),
        .in_bb     (in_bb),
        .in_ahi    (in_ahi),
        .in_bhi    (in_bhi),
        .in_par    (in_par),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_err   (out_err),
        .err_cnt   (err_cnt),
        .word_cnt  (word_cnt)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        err;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];
    int    exp_words = 0;
    int    exp_errs  = 0;
    bit    mon_en = 1'b0;

    logic [31:0] cur_a, cur_b;
    logic        cur_err;
    int          stalls;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: original words go in on input handshakes and must come out in order.
    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            check("word_cnt", 64'(word_cnt), 64'(exp_words));
            check("err_cnt", 64'(err_cnt), 64'(exp_errs));
            if (rst) begin
                exp_q.delete();
                exp_words = 0;
                exp_errs  = 0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("stale_beat", 64'(out_valid), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("out_a", 64'(out_a), 64'(e.a));
                        check("out_b", 64'(out_b), 64'(e.b));
                        check("out_err", 64'(out_err), 64'(e.err));
                        if (e.err && exp_errs < 255) exp_errs++;
                    end
                    exp_words = (exp_words + 1) % 65536;
                end
                if (in_valid && in_ready) begin
                    e.a = cur_a;
                    e.b = cur_b;
                    e.err = cur_err;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Transmitter view: fold the full words, optionally corrupting the a-parity bit.
    task automatic set_beat(input logic [31:0] a, input logic [31:0] b, input bit bad);
        logic [15:0] aa, bb;
        aa       = a[31:16] ^ a[15:0];
        bb       = b[31:16] ^ b[15:0];
        in_aa    = aa;
        in_bb    = bb;
        in_ahi   = a[31:16];
        in_bhi   = b[31:16];
        in_par   = {^bb, (^aa) ^ bad};
        cur_a    = a;
        cur_b    = b;
        cur_err  = PAR_ON & bad;
        in_valid = 1'b1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit bad);
        int n;
        set_beat(a, b, bad);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
        if (n > 0) stalls++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] bp_a[3];
        logic [31:0] bp_b[3];
        int          idx, acc;
        bit          took;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_aa = '0; in_bb = '0; in_ahi = '0; in_bhi = '0; in_par = '0;
        cur_a = '0; cur_b = '0; cur_err = 1'b0; stalls = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_a", 64'(out_a), 64'(0));
        check("rst_out_b", 64'(out_b), 64'(0));
        check("rst_out_err", 64'(out_err), 64'(0));

        // Single beat, two-cycle latency.
        send(32'h12345678, 32'hDEADBEEF, 1'b0);
        in_valid = 1'b0;
        check("single_par", 64'(in_par), 64'(2'b01));
        @(negedge clk);
        check("lat_s1_only", 64'(out_valid), 64'(0));
        @(negedge clk);
        check("lat_valid", 64'(out_valid), 64'(1));
        check("single_a", 64'(out_a), 64'(32'h12345678));
        check("single_b", 64'(out_b), 64'(32'hDEADBEEF));
        check("single_err", 64'(out_err), 64'(0));
        @(negedge clk);
        check("single_cnt", 64'(word_cnt), 64'(1));

        // Back-to-back random stream.
        do_reset();
        stalls = 0;
        for (int i = 0; i < 100; i++) send($urandom, $urandom, 1'b0);
        check("b2b_no_stall", 64'(stalls), 64'(0));
        drain();
        check("b2b_cnt", 64'(word_cnt), 64'(100));

        // Backpressure: three beats offered over five stalled cycles.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        out_ready = 1'b0;
        idx = 0;
        acc = 0;
        set_beat(bp_a[0], bp_b[0], 1'b0);
        repeat (5) begin
            @(negedge clk);
            took = in_ready;
            if (took) acc++;
            @(posedge clk);
            #1;
            if (took) begin
                idx++;
                if (idx < 3) set_beat(bp_a[idx], bp_b[idx], 1'b0);
            end
        end
        @(negedge clk);
        check("bp_accepted", 64'(acc), 64'(2));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_hold_a", 64'(out_a), 64'(bp_a[0]));
        check("bp_hold_b", 64'(out_b), 64'(bp_b[0]));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();
        check("bp_drained", 64'(exp_q.size()), 64'(0));
        check("bp_cnt", 64'(word_cnt), 64'(3));

        // Parity errors and err_cnt saturation.
        do_reset();
        send(32'h12345678, 32'hDEADBEEF, 1'b1);
        check("par_bad_bits", 64'(in_par), 64'(2'b00));
        drain();
        check("par_one", 64'(err_cnt), 64'(PAR_ON ? 1 : 0));
        for (int i = 0; i < 300; i++) send($urandom, $urandom, 1'b1);
        drain();
        check("par_sat", 64'(err_cnt), 64'(PAR_ON ? 255 : 0));

        // word_cnt wrap after 2^16 handshakes.
        do_reset();
        for (int i = 0; i < 65536; i++) send($urandom, $urandom, 1'b0);
        drain();
        check("wrap_cnt", 64'(word_cnt), 64'(0));

        // Reset with both stages full discards in-flight beats.
        do_reset();
        out_ready = 1'b0;
        send($urandom, $urandom, 1'b0);
        send($urandom, $urandom, 1'b0);
        in_valid = 1'b0;
        #1;
        check("full_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_full_valid", 64'(out_valid), 64'(0));
        check("rst_full_ready", 64'(in_ready), 64'(1));
        check("rst_full_wcnt", 64'(word_cnt), 64'(0));
        check("rst_full_ecnt", 64'(err_cnt), 64'(0));
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale", 64'(out_valid), 64'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/xor_unfold_32bit.md
# xor_unfold_32bit

Reconstruction side of the 32→16 XOR fold datapath: accepts folded half-words (aa, bb) together with the upper halves that travelled alongside them, and recovers the full 32-bit a and b words (lo = fold ^ hi). It sits at the receive end of the folded link, behind a valid/ready handshake. It is a two-stage registered pipeline with backpressure, an output word counter and an optional parity check.

## Interface
- HALF_W, 16, folded/half word width; full word is 2*HALF_W
- CNT_W, 16, width of word_cnt
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat
- in_aa  input  HALF_W  folded a (a_lo ^ a_hi)
- in_bb  input  HALF_W  folded b
- in_ahi  input  HALF_W  a[31:16]
- in_bhi  input  HALF_W  b[31:16]
- in_par  input  2  [0] = ^in_aa, [1] = ^in_bb as sent by transmitter
- out_valid  output  1  reconstructed beat valid
- out_ready  input  1  downstream accepts
- out_a  output  2*HALF_W  {in_ahi, in_aa ^ in_ahi}
- out_b  output  2*HALF_W  {in_bhi, in_bb ^ in_bhi}
- out_err  output  1  parity mismatch flag travelling with the beat
- err_cnt  output  8  saturating parity-error count
- word_cnt  output  CNT_W  count of output handshakes

## Operation
- Accept on in_valid && in_ready; emit on out_valid && out_ready.
- Stage 1 (S1) registers raw inputs and in_par. Stage 2 (S2) registers out_a/out_b computed from S1 (XOR done between S1 and S2), plus out_err.
- Advance rules: s2_adv = !s2_valid || out_ready; s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational from out_ready).
- Data registers load only on advance; held stable while out_valid && !out_ready.
- word_cnt increments by 1 per output handshake; wraps 2^CNT_W-1 → 0.
- err_cnt increments by 1 per output handshake with out_err=1; saturates at 255.
- No state machine beyond per-stage valid bits; beats never dropped, duplicated or reordered.

## Timing
- Reset: in_ready=1 after reset (comb.), out_valid=0, out_a=0, out_b=0, out_err=0, err_cnt=0, word_cnt=0, both stage valids 0.
- Latency: beat accepted at cycle N appears on out_valid at N+2 with out_ready held high.
- Throughput: 1 beat/cycle sustained.
- Full (both stages valid, out_ready=0): in_ready=0. Raising out_ready makes in_ready=1 in the same cycle; output, S2 and S1 all shift that edge.
- rst asserted mid-stream: in-flight beats discarded, counters cleared on that edge regardless of handshakes.

## Configuration
- XOR_UNFOLD_PARITY_EN defined: S1→S2 computes out_err = (^in_aa != in_par[0]) || (^in_bb != in_par[1]); err_cnt active.
- Not defined: in_par ignored, out_err and err_cnt tied 0, no parity logic or counter flops; ports remain.

## Structure
- Package xor_fold_pkg: HALF_W/FULL_W localparams, packed struct for an S1 beat (aa, bb, ahi, bhi, par), ERR_CNT_MAX constant.
- Sub-module xor_unfold_stage: one valid/ready register stage with advance logic, instantiated for S1 and S2.

## Test plan
- Single beat: in_aa=0x444C, in_ahi=0x1234, in_bb=0x6042, in_bhi=0xDEAD, in_par=2'b01 → at +2 cycles out_a=0x12345678, out_b=0xDEADBEEF, out_err=0, word_cnt=1.
- Back-to-back 100 random beats, out_ready=1 → matches fold-inverse model, in_ready never drops, word_cnt=100.
- Backpressure: out_ready=0 for 5 cycles while driving 3 beats → exactly 2 accepted, in_ready=0, out_a stable; release → both emitted in order, third then accepted.
- Parity (macro on): beat 1 with in_par=2'b00 → out_err=1, err_cnt=1; 300 bad beats → err_cnt stays 255.
- Wrap: preload via 65536 handshakes (CNT_W=16) → word_cnt returns to 0.
- Reset with both stages full → next cycle out_valid=0, in_ready=1, counters 0; no stale beat emitted.
